// File: rtl/shift_seq.sv
// Multi-mode sequential shifter: one bit position per clock, valid/ready on both sides.
// Define SHIFT_CARRY_EN to add a 'carry' output holding the last bit shifted out.
module shift_seq #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] amt,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SHIFT_CARRY_EN
  ,
  output logic             carry
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [1:0] MODE_LSR = 2'b00;
  localparam logic [1:0] MODE_ASR = 2'b01;
  localparam logic [1:0] MODE_LSL = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             accept_s;
  logic             cnt_zero_s;

  function automatic logic [WIDTH-1:0] shift_val(input logic [WIDTH-1:0] v,
                                                 input logic [1:0]       m);
    logic [WIDTH-1:0] r;
    case (m)
      MODE_LSR: r = {1'b0, v[WIDTH-1:1]};
      MODE_ASR: r = {v[WIDTH-1], v[WIDTH-1:1]};
      MODE_LSL: r = {v[WIDTH-2:0], 1'b0};
      MODE_ROR: r = {v[0], v[WIDTH-1:1]};
      default:  r = {1'b0, v[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  assign accept_s   = (state_q == IDLE) && in_valid && in_ready_q;
  assign cnt_zero_s = (cnt_q == {AMT_W{1'b0}});

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      work_q      <= {WIDTH{1'b0}};
      cnt_q       <= {AMT_W{1'b0}};
      mode_q      <= 2'b00;
      out_q       <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) state_d = SHIFT;
        else          state_d = IDLE;
      end
      SHIFT: begin
        if (cnt_zero_s) state_d = DONE;
        else            state_d = SHIFT;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
        else           state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    out_d  = out_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          work_d = a;
          cnt_d  = amt;
          mode_d = mode;
        end else begin
          work_d = work_q;
        end
      end
      SHIFT: begin
        if (cnt_zero_s) begin
          out_d = work_q;
        end else begin
          work_d = shift_val(work_q, mode_q);
          cnt_d  = cnt_q - AMT_W'(1);
        end
      end
      DONE:    out_d = out_q;
      default: out_d = out_q;
    endcase
    // Handshake flags are registered, so they follow the state being entered.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  assign in_ready  = in_ready_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;

`ifdef SHIFT_CARRY_EN
  logic carry_q, carry_d;

  function automatic logic shift_out_bit(input logic [WIDTH-1:0] v,
                                         input logic [1:0]       m);
    logic b;
    case (m)
      MODE_LSL: b = v[WIDTH-1];
      MODE_LSR: b = v[0];
      MODE_ASR: b = v[0];
      MODE_ROR: b = v[0];
      default:  b = v[0];
    endcase
    return b;
  endfunction

  // Carry register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) carry_q <= 1'b0;
    else        carry_q <= carry_d;
  end

  // Carry captures the bit leaving the word on each step; cleared on accept
  always_comb begin
    carry_d = carry_q;
    if (accept_s) begin
      carry_d = 1'b0;
    end else if ((state_q == SHIFT) && !cnt_zero_s) begin
      carry_d = shift_out_bit(work_q, mode_q);
    end else begin
      carry_d = carry_q;
    end
  end

  assign carry = carry_q;
`endif

endmodule

// File: tb/tb_shift_seq.sv
// Directed self-checking bench for shift_seq (WIDTH=4, AMT_W=3).
module tb_shift_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] a = 4'b0000;
  logic [2:0] amt = 3'b000;
  logic [1:0] mode = 2'b00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] out;
  logic       out_valid;
  logic       out_ready = 1'b1;
`ifdef SHIFT_CARRY_EN
  logic       carry;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  shift_seq #(.WIDTH(4), .AMT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .amt       (amt),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef SHIFT_CARRY_EN
    ,
    .carry     (carry)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble inputs after acceptance, check latency/result/handshake.
  task automatic run_op(input string tag, input logic [1:0] m, input logic [3:0] av,
                        input logic [2:0] am, input logic [3:0] exp_out);
    int lat;
    bit done;
    @(negedge clk);
    check_eq({tag, "_in_ready_idle"}, in_ready, 1);
    mode = m; a = av; amt = am; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = ~av; amt = ~am; mode = ~m;
    lat = 0; done = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      if (out_valid) done = 1;
      else lat++;
    end
    check_eq({tag, "_completed"}, done, 1);
    check_eq({tag, "_latency"}, lat, am + 1);
    check_eq({tag, "_out"}, out, exp_out);
    check_eq({tag, "_in_ready_done"}, in_ready, 0);
    if (out_ready) begin
      @(negedge clk);
      check_eq({tag, "_out_valid_drop"}, out_valid, 0);
      check_eq({tag, "_in_ready_back"}, in_ready, 1);
      check_eq({tag, "_out_held"}, out, exp_out);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_out", out, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;

    run_op("lsr1",  2'b00, 4'b1000, 3'd1, 4'b0100);
    run_op("asr2",  2'b01, 4'b1000, 3'd2, 4'b1110);
    run_op("asr7",  2'b01, 4'b0100, 3'd7, 4'b0000);
    run_op("asr7n", 2'b01, 4'b1010, 3'd7, 4'b1111);
    run_op("lsr6",  2'b00, 4'b1111, 3'd6, 4'b0000);
    run_op("lsl1",  2'b10, 4'b0010, 3'd1, 4'b0100);
    run_op("lsl3",  2'b10, 4'b0111, 3'd3, 4'b1000);
    run_op("ror1",  2'b11, 4'b0001, 3'd1, 4'b1000);
    run_op("ror5",  2'b11, 4'b0001, 3'd5, 4'b1000);
    run_op("ror2",  2'b11, 4'b0110, 3'd2, 4'b1001);

`ifdef SHIFT_CARRY_EN
    run_op("c_lsr", 2'b00, 4'b0011, 3'd1, 4'b0001);
    check_eq("c_lsr_carry", carry, 1);
    run_op("c_lsl", 2'b10, 4'b0111, 3'd2, 4'b1100);
    check_eq("c_lsl_carry", carry, 1);
    run_op("c_ror", 2'b11, 4'b0110, 3'd1, 4'b0011);
    check_eq("c_ror_carry", carry, 0);
    run_op("c_ror2", 2'b11, 4'b0101, 3'd1, 4'b1010);
    check_eq("c_ror2_carry", carry, 1);
    run_op("c_amt0", 2'b00, 4'b1111, 3'd0, 4'b1111);
    check_eq("c_amt0_carry", carry, 0);
`endif

    // amt = 0 with the consumer stalled: result must be held
    out_ready = 1'b0;
    run_op("hold", 2'b00, 4'b1011, 3'd0, 4'b1011);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("hold_out_valid", out_valid, 1);
      check_eq("hold_out", out, 4'b1011);
      check_eq("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("hold_release_valid", out_valid, 0);
    check_eq("hold_release_ready", in_ready, 1);

    // Reset in the third SHIFT cycle discards the op
    @(negedge clk);
    mode = 2'b00; a = 4'b1111; amt = 3'd6; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_in_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out", out, 0);
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 2'b00, 4'b0001, 3'd0, 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
